freelist_ckpt: RTL and testbench

- Parametrised successor to the rename free list: a circular FIFO of free physical-register tags.
- Rename pops tags from the head. Commit pushes retired tags at the tail.
- Branch checkpoints snapshot only the head pointer into NUM_CKPT slots; restore rewinds the head in one cycle instead of copying the whole array.
- Sits between the RAT/rename stage and commit.

---
 rtl/freelist_ckpt.sv | 111 +++++++++++
 tb/tb_freelist_ckpt.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/freelist_ckpt.sv
// Circular free list of physical-register tags with head-pointer checkpoints.
// Define FREELIST_BYPASS_EN to forward a same-cycle released tag to an allocation when the list is empty.
module freelist_ckpt #(
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 128,
  parameter int ARCH_REGS = 32,
  parameter int NUM_CKPT  = 8,
  parameter int CKPT_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_req,
  output logic                     alloc_gnt,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic                     release_valid,
  input  logic [TAG_W-1:0]         release_tag,
  input  logic                     ckpt_save,
  input  logic [CKPT_W-1:0]        ckpt_save_id,
  input  logic                     ckpt_restore,
  input  logic [CKPT_W-1:0]        ckpt_restore_id,
  input  logic                     ckpt_clear,
  input  logic [CKPT_W-1:0]        ckpt_clear_id,
  output logic [NUM_CKPT-1:0]      ckpt_valid,
  output logic [$clog2(DEPTH):0]   free_count,
  output logic                     empty,
  output logic                     full,
  output logic                     err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [TAG_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    ckpt_head_q [NUM_CKPT];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]    count_q, count_d;
  logic [NUM_CKPT-1:0] ckpt_valid_q, ckpt_valid_d;
  logic                empty_q, full_q, err_q, err_d;
  logic                bypass, rel_wr, restore_ok;
  logic [PTR_W-1:0]    restore_head, restore_count;

  always_comb begin
    bypass = 1'b0;
`ifdef FREELIST_BYPASS_EN
    bypass = empty_q & release_valid & alloc_req & ~ckpt_restore;
`endif
    restore_ok    = ckpt_restore & ckpt_valid_q[ckpt_restore_id];
    restore_head  = ckpt_head_q[ckpt_restore_id];
    alloc_gnt     = (alloc_req & ~empty_q & ~ckpt_restore) | bypass;
    alloc_tag     = bypass ? release_tag : mem_q[head_q[IDX_W-1:0]];
    // A bypassed tag never enters the array, so neither pointer moves.
    rel_wr        = release_valid & ~full_q & ~bypass;
    tail_d        = tail_q + PTR_W'(rel_wr);

    head_d = head_q;
    if (restore_ok)
      head_d = restore_head;
    else if (alloc_gnt & ~bypass)
      head_d = head_q + PTR_W'(1);

    count_d       = tail_d - head_d;
    restore_count = tail_d - restore_head;

    err_d = err_q
          | (release_valid & full_q)
          | (ckpt_restore & ~ckpt_valid_q[ckpt_restore_id])
          | (restore_ok & (restore_count > DEPTH_P));

    // Save is applied after clear so a same-id save keeps the slot valid.
    ckpt_valid_d = ckpt_valid_q;
    if (ckpt_clear) ckpt_valid_d[ckpt_clear_id] = 1'b0;
    if (ckpt_save)  ckpt_valid_d[ckpt_save_id]  = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= DEPTH_P;
      count_q      <= DEPTH_P;
      empty_q      <= 1'b0;
      full_q       <= 1'b1;
      err_q        <= 1'b0;
      ckpt_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= TAG_W'(ARCH_REGS + i);
      for (int i = 0; i < NUM_CKPT; i++)
        ckpt_head_q[i] <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      empty_q      <= (count_d == '0);
      full_q       <= (count_d == DEPTH_P);
      err_q        <= err_d;
      ckpt_valid_q <= ckpt_valid_d;
      if (rel_wr)
        mem_q[tail_q[IDX_W-1:0]] <= release_tag;
      // The snapshot is the post-grant (or restored) head.
      if (ckpt_save)
        ckpt_head_q[ckpt_save_id] <= head_d;
    end
  end

  assign ckpt_valid = ckpt_valid_q;
  assign free_count = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_freelist_ckpt.sv
// Scoreboard bench for freelist_ckpt: a behavioural free-list model predicts grants, tags and status.
module tb_freelist_ckpt;

  localparam int TAG_W     = 8;
  localparam int DEPTH     = 128;
  localparam int ARCH_REGS = 32;
  localparam int NUM_CKPT  = 8;
  localparam int CKPT_W    = 3;
  localparam int MODW      = 2 * DEPTH;
`ifdef FREELIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset = 1'b1;
  logic                  alloc_req = 1'b0;
  logic                  alloc_gnt;
  logic [TAG_W-1:0]      alloc_tag;
  logic                  release_valid = 1'b0;
  logic [TAG_W-1:0]      release_tag = '0;
  logic                  ckpt_save = 1'b0;
  logic [CKPT_W-1:0]     ckpt_save_id = '0;
  logic                  ckpt_restore = 1'b0;
  logic [CKPT_W-1:0]     ckpt_restore_id = '0;
  logic                  ckpt_clear = 1'b0;
  logic [CKPT_W-1:0]     ckpt_clear_id = '0;
  logic [NUM_CKPT-1:0]   ckpt_valid;
  logic [$clog2(DEPTH):0] free_count;
  logic                  empty, full, err;

  freelist_ckpt #(
    .TAG_W(TAG_W), .DEPTH(DEPTH), .ARCH_REGS(ARCH_REGS),
    .NUM_CKPT(NUM_CKPT), .CKPT_W(CKPT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .release_valid(release_valid), .release_tag(release_tag),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
    .ckpt_clear(ckpt_clear), .ckpt_clear_id(ckpt_clear_id),
    .ckpt_valid(ckpt_valid), .free_count(free_count),
    .empty(empty), .full(full), .err(err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: unbounded head/tail counters, status taken modulo 2*DEPTH.
  int               m_head, m_tail;
  logic [TAG_W-1:0] m_mem [DEPTH];
  int               m_ck [NUM_CKPT];
  bit [NUM_CKPT-1:0] m_cv;
  bit               m_err;
  logic [TAG_W-1:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int mcnt();
    return (((m_tail - m_head) % MODW) + MODW) % MODW;
  endfunction

  task automatic model_reset();
    m_head = 0;
    m_tail = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = TAG_W'(ARCH_REGS + i);
    for (int i = 0; i < NUM_CKPT; i++) m_ck[i] = 0;
    m_cv  = '0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_status(input string pfx);
    check({pfx, "_free_count"}, int'(free_count), mcnt());
    check({pfx, "_empty"},      int'(empty),      int'(mcnt() == 0));
    check({pfx, "_full"},       int'(full),       int'(mcnt() == DEPTH));
    check({pfx, "_err"},        int'(err),        int'(m_err));
    check({pfx, "_ckpt_valid"}, int'(ckpt_valid), int'(m_cv));
  endtask

  // Called at a falling edge; asserts reset asynchronously between edges.
  task automatic do_reset();
    alloc_req = 1'b0; release_valid = 1'b0; ckpt_save = 1'b0;
    ckpt_restore = 1'b0; ckpt_clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_status("rst");
    check("rst_alloc_gnt", int'(alloc_gnt), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle of stimulus; called and returns at a falling edge.
  task automatic cycle(input bit req, input bit rv, input int rtag,
                       input bit sv, input int sid, input bit rs, input int rid,
                       input bit cl, input int cid);
    int cnt;
    bit byp, gnt;
    alloc_req       = req;
    release_valid   = rv;
    release_tag     = TAG_W'(rtag);
    ckpt_save       = sv;
    ckpt_save_id    = CKPT_W'(sid);
    ckpt_restore    = rs;
    ckpt_restore_id = CKPT_W'(rid);
    ckpt_clear      = cl;
    ckpt_clear_id   = CKPT_W'(cid);

    cnt = mcnt();
    byp = BYP && cnt == 0 && rv && req && !rs;
    gnt = byp || (req && cnt != 0 && !rs);
    if (gnt) exp_q.push_back(byp ? TAG_W'(rtag) : m_mem[m_head % DEPTH]);

    #2;
    check("alloc_gnt", int'(alloc_gnt), int'(gnt));
    if (alloc_gnt) begin
      if (exp_q.size() == 0) check("alloc_unexpected", int'(alloc_gnt), 0);
      else check("alloc_tag", int'(alloc_tag), int'(exp_q.pop_front()));
    end
    exp_q.delete();

    if (rv && cnt == DEPTH) m_err = 1'b1;
    if (rs && !m_cv[rid]) m_err = 1'b1;
    if (rv && cnt != DEPTH && !byp) begin
      m_mem[m_tail % DEPTH] = TAG_W'(rtag);
      m_tail++;
    end
    if (rs && m_cv[rid]) begin
      m_head = m_ck[rid];
      if (mcnt() > DEPTH) m_err = 1'b1;
    end else if (gnt && !byp) begin
      m_head++;
    end
    if (cl) m_cv[cid] = 1'b0;
    if (sv) begin
      m_ck[sid] = m_head;
      m_cv[sid] = 1'b1;
    end

    @(posedge clk);
    #1;
    check_status("cyc");
    @(negedge clk);
  endtask

  task automatic alloc1();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle1();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Three back-to-back allocations: 32, 33, 34.
    alloc_req = 1'b1;
    #1 check("first_tag", int'(alloc_tag), ARCH_REGS);
    repeat (3) alloc1();
    check("count_after3", int'(free_count), DEPTH - 3);

    // Drain the rest, then keep asking on an empty list.
    repeat (DEPTH - 3) alloc1();
    check("drained_empty", int'(empty), 1);
    check("drained_count", int'(free_count), 0);
    repeat (3) alloc1();
    check("empty_no_err", int'(err), 0);

    // Release tag 200 with a same-cycle request on the empty list.
    cycle(1, 1, 200, 0, 0, 0, 0, 0, 0);
    check("empty_rel_count", int'(free_count), BYP ? 0 : 1);
    idle1();

    // Release into a full list is dropped and flagged.
    do_reset();
    cycle(0, 1, 7, 0, 0, 0, 0, 0, 0);
    check("full_rel_err", int'(err), 1);
    check("full_rel_count", int'(free_count), DEPTH);

    // Checkpoint on the allocation of 33, consume 34/35, then restore.
    do_reset();
    alloc1();
    cycle(1, 0, 0, 1, 2, 0, 0, 0, 0);
    check("ckpt2_valid", int'(ckpt_valid), 4);
    alloc1();
    alloc1();
    cycle(1, 0, 0, 0, 0, 1, 2, 0, 0);
    check("restore_count", int'(free_count), DEPTH - 2);
    alloc_req = 1'b1;
    #1 check("restore_tag", int'(alloc_tag), ARCH_REGS + 2);
    alloc1();

    // Restore from a never-saved slot.
    cycle(0, 0, 0, 0, 0, 1, 5, 0, 0);
    check("bad_restore_err", int'(err), 1);
    check("bad_restore_count", int'(free_count), DEPTH - 3);

    // Save and restore together, and clear/save on the same slot.
    cycle(1, 0, 0, 1, 4, 1, 2, 0, 0);
    cycle(0, 0, 0, 1, 3, 0, 0, 1, 3);
    check("clear_save_valid", int'(ckpt_valid[3]), 1);

    // Mixed random traffic with a mid-run asynchronous reset.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
            int'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 12, int'($urandom_range(0, NUM_CKPT - 1)),
            $urandom_range(0, 99) < 5,  int'($urandom_range(0, NUM_CKPT - 1)),
            $urandom_range(0, 99) < 10, int'($urandom_range(0, NUM_CKPT - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
